// File: rtl/fulladder_selec.sv
// fulladder_selec: selectable ripple adder / subtractor with registered outputs.
// The add/subtract decision is made per bit inside the ripple chain. The result
// and the final carry/borrow are captured every clock. There is no enable.
module fulladder_selec #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             selector,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // chain[i] is the carry (add) or borrow (subtract) entering bit i.
  // chain[WIDTH] leaves the MSB and becomes cout.
  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] res_d;

  assign chain[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic x;
    logic carry_next;
    logic borrow_next;

    // The sum bit and the difference bit are the same XOR. Only the next
    // carry/borrow term depends on the mode.
    assign x           = a[i] ^ b[i];
    assign res_d[i]    = x ^ chain[i];
    assign carry_next  = (a[i] & b[i]) | (chain[i] & x);
    assign borrow_next = (~a[i] & b[i]) | (~x & chain[i]);
    assign chain[i+1]  = selector ? borrow_next : carry_next;
  end

  // Capture the result every cycle. Reset clears it at once, without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= res_d;
      cout <= chain[WIDTH];
    end
  end

endmodule

// File: tb/tb_fulladder_selec.sv
// tb_fulladder_selec: directed and random checks of the WIDTH=1 and WIDTH=4 builds
// against a plain-arithmetic reference model.
module tb_fulladder_selec;

  logic       clk;
  logic       rst;
  logic       a1, b1;
  logic [3:0] a4, b4;
  logic       cin;
  logic       selector;
  logic       sum1, cout1;
  logic [3:0] sum4;
  logic       cout4;

  int checks = 0;
  int fails  = 0;

  fulladder_selec #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin), .selector(selector),
    .sum(sum1), .cout(cout1)
  );

  fulladder_selec #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin), .selector(selector),
    .sum(sum4), .cout(cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_sum(int w, int a, int b, int c, int s);
    int mask = (1 << w) - 1;
    if (s != 0) return (a - b - c) & mask;
    return (a + b + c) & mask;
  endfunction

  function automatic int model_cout(int w, int a, int b, int c, int s);
    if (s != 0) return (a < b + c) ? 1 : 0;
    return ((a + b + c) >> w) & 1;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive both instances, let one rising edge pass, then compare against the model.
  task automatic step(input string tag, input int va1, input int vb1,
                      input int va4, input int vb4, input int vc, input int vs);
    int e_s1, e_c1, e_s4, e_c4;
    a1 = va1[0]; b1 = vb1[0];
    a4 = va4[3:0]; b4 = vb4[3:0];
    cin = vc[0]; selector = vs[0];
    e_s1 = model_sum(1, va1 & 1, vb1 & 1, vc & 1, vs & 1);
    e_c1 = model_cout(1, va1 & 1, vb1 & 1, vc & 1, vs & 1);
    e_s4 = model_sum(4, va4 & 15, vb4 & 15, vc & 1, vs & 1);
    e_c4 = model_cout(4, va4 & 15, vb4 & 15, vc & 1, vs & 1);
    @(posedge clk);
    #1;
    chk({tag, ".sum1"},  int'(sum1),  e_s1);
    chk({tag, ".cout1"}, int'(cout1), e_c1);
    chk({tag, ".sum4"},  int'(sum4),  e_s4);
    chk({tag, ".cout4"}, int'(cout4), e_c4);
  endtask

  initial begin
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; a4 = 4'd0; b4 = 4'd0; cin = 1'b0; selector = 1'b0;
    #3;
    chk("reset.sum1",  int'(sum1),  0);
    chk("reset.cout1", int'(cout1), 0);
    chk("reset.sum4",  int'(sum4),  0);
    chk("reset.cout4", int'(cout4), 0);
    @(negedge clk);
    rst = 1'b0;

    // add
    step("add_100", 1, 0, 9, 4, 0, 0);
    step("add_010", 0, 1, 3, 12, 0, 0);
    step("add_110", 1, 1, 8, 8, 0, 0);
    step("add_111", 1, 1, 15, 15, 1, 0);
    chk("add_111.lit_sum4", int'(sum4), 15);
    chk("add_111.lit_cout4", int'(cout4), 1);
    chk("add_111.lit_sum1", int'(sum1), 1);
    chk("add_111.lit_cout1", int'(cout1), 1);

    // subtract
    step("sub_111", 1, 1, 5, 5, 1, 1);
    step("sub_011", 0, 1, 2, 7, 1, 1);
    step("sub_100", 1, 0, 12, 3, 0, 1);
    step("sub_001", 0, 0, 0, 0, 1, 1);
    chk("sub_001.lit_sum4", int'(sum4), 15);
    chk("sub_001.lit_cout4", int'(cout4), 1);
    step("sub_eq", 1, 1, 10, 10, 0, 1);
    chk("sub_eq.lit_sum4", int'(sum4), 0);
    chk("sub_eq.lit_cout4", int'(cout4), 0);

    // Mode toggle with operands held.
    step("tog_add", 1, 1, 6, 6, 0, 0);
    chk("tog_add.lit", {int'(sum1), int'(cout1)} == {32'd0, 32'd1} ? 1 : 0, 1);
    step("tog_sub", 1, 1, 6, 6, 0, 1);
    chk("tog_sub.lit", {int'(sum1), int'(cout1)} == {32'd0, 32'd0} ? 1 : 0, 1);

    // Reset between edges while the outputs are nonzero.
    step("pre_rst", 1, 1, 15, 15, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async.sum1",  int'(sum1),  0);
    chk("rst_async.cout1", int'(cout1), 0);
    chk("rst_async.sum4",  int'(sum4),  0);
    chk("rst_async.cout4", int'(cout4), 0);
    @(posedge clk);
    #1;
    chk("rst_hold.sum4", int'(sum4), 0);
    chk("rst_hold.sum1", int'(sum1), 0);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1, 0, 1, 0, 0, 0);
    chk("post_rst.lit_sum1", int'(sum1), 1);

    // Exhaustive on the one-bit slice, random operands for the four-bit build.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("exh%0d", i), i & 1, (i >> 1) & 1,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           (i >> 2) & 1, (i >> 3) & 1);
    end

    for (int i = 0; i < 40; i++) begin
      step($sformatf("rnd%0d", i), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
